// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, mid-bit sampling FSM, LSB-first payload,
// single-cycle valid/break strobes. A frame with all-zero payload and low stop bit is a break.
module uart_rx #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_break,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data
);

  localparam int          CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam logic [15:0] CPB            = 16'(CYCLES_PER_BIT);
  localparam logic [15:0] HALF           = 16'(CYCLES_PER_BIT / 2);
  localparam logic [3:0]  LAST_BIT       = 4'(PAYLOAD_BITS - 1);

  generate
    if (PAYLOAD_BITS < 1 || PAYLOAD_BITS > 15 || STOP_BITS < 1 || STOP_BITS > 2 ||
        CYCLES_PER_BIT < 2 || CYCLES_PER_BIT > 65535) begin : g_bad_param
      $error("uart_rx: unsupported parameter combination");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, RECV, STOP} state_t;

  state_t                  state, state_nxt;
  logic                    rxd_m, rxd_s;
  logic [15:0]             cnt, cnt_nxt;
  logic [3:0]              bit_cnt, bit_cnt_nxt;
  logic [PAYLOAD_BITS-1:0] sr, sr_nxt;
  logic [PAYLOAD_BITS-1:0] data_nxt;
  logic                    armed, armed_nxt;
  logic                    valid_nxt, break_nxt;

  // cnt counts cycles spent in the current bit including this one, so an event
  // at cnt == CPB recurs exactly every CPB cycles.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 16'd1;
    bit_cnt_nxt = bit_cnt;
    sr_nxt      = sr;
    data_nxt    = uart_rx_data;
    armed_nxt   = armed;
    valid_nxt   = 1'b0;
    break_nxt   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (rxd_s) armed_nxt = 1'b1;
        if (uart_rx_en && !rxd_s && armed) begin
          state_nxt   = START;
          cnt_nxt     = 16'd1;
          bit_cnt_nxt = '0;
          sr_nxt      = '0;
        end
      end
      START: begin
        if (cnt == HALF) begin
          cnt_nxt   = 16'd1;
          state_nxt = rxd_s ? IDLE : RECV;
        end
      end
      RECV: begin
        if (cnt == CPB) begin
          cnt_nxt                  = 16'd1;
          sr_nxt                   = sr >> 1;
          sr_nxt[PAYLOAD_BITS-1]   = rxd_s;
          bit_cnt_nxt              = bit_cnt + 4'd1;
          if (bit_cnt == LAST_BIT) state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == CPB) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          // a held-low line must go high before the next start is accepted
          armed_nxt = 1'b0;
          if (rxd_s) begin
            valid_nxt = 1'b1;
            data_nxt  = sr;
          end else if (sr == '0) begin
            break_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_m         <= 1'b1;
      rxd_s         <= 1'b1;
      state         <= IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      sr            <= '0;
      armed         <= 1'b1;
      uart_rx_valid <= 1'b0;
      uart_rx_break <= 1'b0;
      uart_rx_data  <= '0;
    end else begin
      rxd_m         <= uart_rxd;
      rxd_s         <= rxd_m;
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      bit_cnt       <= bit_cnt_nxt;
      sr            <= sr_nxt;
      armed         <= armed_nxt;
      uart_rx_valid <= valid_nxt;
      uart_rx_break <= break_nxt;
      uart_rx_data  <= data_nxt;
    end
  end

endmodule
